conv_stream_blk: RTL

Parametrised streaming 2-D convolution engine; successor to `conv_blk`. It loads one K×K signed kernel, then consumes a raster-ordered feature map under a valid/ready handshake. Line buffers build the sliding window and a registered multiply/adder tree produces one wide result per output position, honouring STRIDE. It sits between the feature-map/weight BRAM readers and the output-map writer (or a downstream pooling stage).

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_stream_blk_if.sv | 27 ++
 rtl/conv_stream_blk_line_buffer.sv | 21 ++
 rtl/conv_stream_blk.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Register stages between an accepting edge and the o_en strobe.
  localparam int unsigned PIPE_LATENCY = 3;

  function automatic int unsigned out_size(input int unsigned n, input int unsigned k,
                                           input int unsigned s);
    return (n - k) / s + 1;
  endfunction

endpackage

// File: rtl/conv_stream_blk_if.sv
// Weight/feature-map/result bundle of conv_stream_blk; the block takes the slave side.
interface conv_stream_blk_if #(
  parameter int unsigned DATA_WIDTH   = 30,
  parameter int unsigned WEIGHT_WIDTH = 18,
  parameter int unsigned ACC_WIDTH    = 48
);
  logic                    i_go;
  logic [WEIGHT_WIDTH-1:0] i_weight_data;
  logic                    i_weight_valid;
  logic [DATA_WIDTH-1:0]   i_fm_data;
  logic                    i_fm_valid;
  logic                    o_fm_ready;
  logic                    o_en;
  logic [ACC_WIDTH-1:0]    o_conv_result;
  logic                    o_done;
  logic                    o_busy;

  modport slave (
    input  i_go, i_weight_data, i_weight_valid, i_fm_data, i_fm_valid,
    output o_fm_ready, o_en, o_conv_result, o_done, o_busy
  );

  modport master (
    output i_go, i_weight_data, i_weight_valid, i_fm_data, i_fm_valid,
    input  o_fm_ready, o_en, o_conv_result, o_done, o_busy
  );
endinterface

// File: rtl/conv_stream_blk_line_buffer.sv
// One-row delay line: delayed is the sample pushed DEPTH shifts ago. Contents are not reset.
module line_buffer #(
  parameter int unsigned DEPTH = 252,
  parameter int unsigned WIDTH = 30
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] delayed
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= sample;
      for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign delayed = mem[DEPTH-1];
endmodule

// File: rtl/conv_stream_blk.sv
// Streaming KxK convolution: kernel load, line-buffered window, registered multiply/adder tree.
// Optional CONV_RELU_EN clamps negative sums to zero in the output stage.
module conv_stream_blk
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned FM_SIZE      = 252,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned DATA_WIDTH   = 30,
  parameter int unsigned WEIGHT_WIDTH = 18,
  parameter int unsigned ACC_WIDTH    = 48
) (
  input logic              i_clk,
  input logic              i_rst,
  conv_stream_blk_if.slave bus
);
  localparam int unsigned KK  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned CW  = $clog2(FM_SIZE + 1);
  localparam int unsigned SW  = $clog2(STRIDE + 1);
  localparam int unsigned WCW = $clog2(KK + 1);
  localparam int unsigned PW  = DATA_WIDTH + WEIGHT_WIDTH;

  state_t                         state;
  logic [WCW-1:0]                 wcnt;
  logic [1:0]                     dcnt;
  logic [CW-1:0]                  col, row;
  logic [SW-1:0]                  col_ph, row_ph;
  logic signed [WEIGHT_WIDTH-1:0] weights [KK];
  logic                           fm_ready, busy, done;

  logic accept, last_col, last_row, emit;

  assign accept   = bus.i_fm_valid && fm_ready;
  assign last_col = (col == CW'(FM_SIZE - 1));
  assign last_row = (row == CW'(FM_SIZE - 1));
  assign emit     = accept && (row >= CW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1))
                    && (row_ph == '0) && (col_ph == '0);

  // Phase counters track (pos-K+1) mod STRIDE without a divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      dcnt     <= '0;
      col      <= '0;
      row      <= '0;
      col_ph   <= '0;
      row_ph   <= '0;
      fm_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < KK; i++) weights[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_go) begin
            state <= LOAD_W;
            wcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD_W: begin
          if (bus.i_weight_valid) begin
            weights[wcnt] <= bus.i_weight_data;
            if (wcnt == WCW'(KK - 1)) begin
              state    <= RUN;
              fm_ready <= 1'b1;
              col      <= '0;
              row      <= '0;
              col_ph   <= '0;
              row_ph   <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (last_col) begin
              col    <= '0;
              col_ph <= '0;
              row    <= row + 1'b1;
              if (row >= CW'(KERNEL_SIZE - 1))
                row_ph <= (row_ph == SW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
              if (last_row) begin
                state    <= DRAIN;
                fm_ready <= 1'b0;
                dcnt     <= '0;
              end
            end else begin
              col <= col + 1'b1;
              if (col >= CW'(KERNEL_SIZE - 1))
                col_ph <= (col_ph == SW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == 2'(PIPE_LATENCY - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // col_in[K-1] is the incoming pixel; each line buffer supplies the same column one row higher.
  logic [DATA_WIDTH-1:0] col_in [KERNEL_SIZE];
  assign col_in[KERNEL_SIZE-1] = bus.i_fm_data;

  for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_lb
    line_buffer #(
      .DEPTH(FM_SIZE),
      .WIDTH(DATA_WIDTH)
    ) u_lb (
      .clk    (i_clk),
      .en     (accept),
      .sample (col_in[KERNEL_SIZE-1-g]),
      .delayed(col_in[KERNEL_SIZE-2-g])
    );
  end

  logic signed [DATA_WIDTH-1:0] win [KERNEL_SIZE][KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]  prod [KK];
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  result;
  logic                         v_win, v_prod, en;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < KK; i++) sum = sum + prod[i];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_win  <= 1'b0;
      v_prod <= 1'b0;
      en     <= 1'b0;
      result <= '0;
      for (int unsigned i = 0; i < KERNEL_SIZE; i++)
        for (int unsigned j = 0; j < KERNEL_SIZE; j++) win[i][j] <= '0;
      for (int unsigned i = 0; i < KK; i++) prod[i] <= '0;
    end else begin
      v_win <= emit;
      if (accept) begin
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
          for (int unsigned j = 0; j < KERNEL_SIZE - 1; j++) win[i][j] <= win[i][j+1];
          win[i][KERNEL_SIZE-1] <= col_in[i];
        end
      end
      v_prod <= v_win;
      for (int unsigned i = 0; i < KERNEL_SIZE; i++)
        for (int unsigned j = 0; j < KERNEL_SIZE; j++)
          prod[i*KERNEL_SIZE+j] <= ACC_WIDTH'(PW'(win[i][j]) * PW'(weights[i*KERNEL_SIZE+j]));
      en <= v_prod;
      if (v_prod) begin
`ifdef CONV_RELU_EN
        result <= sum[ACC_WIDTH-1] ? '0 : sum;
`else
        result <= sum;
`endif
      end
    end
  end

  assign bus.o_fm_ready    = fm_ready;
  assign bus.o_en          = en;
  assign bus.o_conv_result = result;
  assign bus.o_done        = done;
  assign bus.o_busy        = busy;
endmodule
